// File: rtl/zuc_inject_buf.sv
`default_nettype none
// ============================================================================
//  Module      : zuc_inject_buf
//  Description : AXI4-Lite loaded 512b line FIFO replayed as an axi4stream
//                master for directed stimulus injection into the ZUC datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module zuc_inject_buf #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          inject_clk,
    input  logic          inject_reset_n,
    input  logic          inject_sw_reset,
    input  logic          inject_enable,
    input  logic [19:0]   axi4lite_awaddr_base,
    input  logic [19:0]   axi4lite_awaddr,
    input  logic          axi4lite_awvalid,
    output logic          axi4lite_awready,
    input  logic [31:0]   axi4lite_wdata,
    input  logic          axi4lite_wvalid,
    output logic          axi4lite_wready,
    output logic          axi4lite_bvalid,
    input  logic          axi4lite_bready,
    output logic [1:0]    axi4lite_bresp,
    output logic [511:0]  inject_tdata,
    output logic          inject_tvalid,
    input  logic          inject_tready,
    output logic          inject_tlast,
    output logic          inject_eom,
    output logic [CW-1:0] inject_fifo_count,
    output logic          inject_overflow
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_apply = 2'd1;
    localparam logic [1:0]    c_st_resp  = 2'd2;
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_aw_held;
    logic          r_w_held;
    logic [19:0]   r_awaddr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_bresp;
    logic [511:0]  r_staging;
    logic          r_tlast_lat;
    logic          r_eom_lat;
    logic [515:0]  r_mem [DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic          r_tvalid;
    logic [511:0]  r_tdata;
    logic          r_tlast;
    logic          r_eom;
    logic          r_overflow;

    logic          w_aw_fire;
    logic          w_w_fire;
    logic          w_apply;
    logic          w_hit;
    logic          w_dw_sel;
    logic          w_ctrl_sel;
    logic          w_commit;
    logic          w_line_tlast;
    logic          w_line_eom;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign axi4lite_awready  = (r_state == c_st_idle) && !r_aw_held;
    assign axi4lite_wready   = (r_state == c_st_idle) && !r_w_held;
    assign axi4lite_bvalid   = (r_state == c_st_resp);
    assign axi4lite_bresp    = r_bresp;
    assign inject_tdata      = r_tdata;
    assign inject_tvalid     = r_tvalid;
    assign inject_tlast      = r_tlast;
    assign inject_eom        = r_eom;
    assign inject_fifo_count = w_count;
    assign inject_overflow   = r_overflow;

    assign w_aw_fire = axi4lite_awvalid && axi4lite_awready;
    assign w_w_fire  = axi4lite_wvalid && axi4lite_wready;
    assign w_apply   = (r_state == c_st_apply);

    // Address decode operates on the captured AW beat during APPLY
    assign w_hit      = ({r_awaddr[19:8], 8'h00} == axi4lite_awaddr_base);
    assign w_dw_sel   = w_hit && (r_awaddr[7:6] == 2'b00) && (r_awaddr[1:0] == 2'b00);
    assign w_ctrl_sel = w_hit && (r_awaddr[7:0] == 8'h40);
    assign w_commit   = w_apply && w_ctrl_sel && r_wdata[31] && !inject_sw_reset;

    // A committing control write also supplies the line's tlast/eom
    assign w_line_tlast = w_ctrl_sel ? r_wdata[0] : r_tlast_lat;
    assign w_line_eom   = w_ctrl_sel ? r_wdata[1] : r_eom_lat;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_depth);
    assign w_empty = (w_count == '0);
    assign w_pop   = (!r_tvalid || inject_tready) && !w_empty && inject_enable
                     && !inject_sw_reset;
    assign w_push  = w_commit && (!w_full || w_pop);
    assign w_drop  = w_commit && !w_push;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if ((r_aw_held || w_aw_fire) && (r_w_held || w_w_fire))
                    w_state_nxt = c_st_apply;
            end
            c_st_apply: w_state_nxt = c_st_resp;
            c_st_resp: begin
                if (axi4lite_bready)
                    w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge inject_clk or negedge inject_reset_n) begin
        if (!inject_reset_n) begin
            r_state   <= c_st_idle;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bresp   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_apply) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_drop ? 2'b10 : 2'b00;
            end else begin
                if (w_aw_fire) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= axi4lite_awaddr;
                end
                if (w_w_fire) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= axi4lite_wdata;
                end
            end
        end
    end

    always_ff @(posedge inject_clk or negedge inject_reset_n) begin
        if (!inject_reset_n) begin
            r_staging   <= '0;
            r_tlast_lat <= 1'b0;
            r_eom_lat   <= 1'b0;
        end else if (inject_sw_reset) begin
            r_staging   <= '0;
            r_tlast_lat <= 1'b0;
            r_eom_lat   <= 1'b0;
        end else if (w_apply && w_dw_sel) begin
            r_staging[{r_awaddr[5:2], 5'd0} +: 32] <= r_wdata;
        end else if (w_apply && w_ctrl_sel) begin
            r_tlast_lat <= r_wdata[0];
            r_eom_lat   <= r_wdata[1];
        end
    end

    // Line storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge inject_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[CW-2:0]] <= {w_line_eom, w_line_tlast, 2'b00, r_staging};
    end

    always_ff @(posedge inject_clk or negedge inject_reset_n) begin
        if (!inject_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (inject_sw_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + CW'(1);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge inject_clk or negedge inject_reset_n) begin
        if (!inject_reset_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_eom    <= 1'b0;
        end else if (inject_sw_reset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_eom    <= 1'b0;
        end else if (w_pop) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_mem[r_rd_ptr[CW-2:0]][511:0];
            r_tlast  <= r_mem[r_rd_ptr[CW-2:0]][514];
            r_eom    <= r_mem[r_rd_ptr[CW-2:0]][515];
        end else if (inject_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zuc_inject_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zuc_inject_buf
//  Description : Directed and randomized checks of zuc_inject_buf against a
//                line-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zuc_inject_buf;

    localparam int         DEPTH = 16;
    localparam int         CW    = 5;
    localparam logic [19:0] BASE = 20'hA5300;

    typedef struct packed {
        logic [511:0] d;
        logic         l;
        logic         e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sw_reset;
    logic          enable;
    logic [19:0]   awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic          wvalid;
    logic          wready;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic [511:0]  tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          eom;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_tv   = 0;
    logic          rand_rdy = 1'b0;
    logic [31:0]   m_stg [16];
    beat_t         exp_q [$];

    zuc_inject_buf #(.DEPTH(DEPTH)) dut (
        .inject_clk           (clk),
        .inject_reset_n       (rst_n),
        .inject_sw_reset      (sw_reset),
        .inject_enable        (enable),
        .axi4lite_awaddr_base (BASE),
        .axi4lite_awaddr      (awaddr),
        .axi4lite_awvalid     (awvalid),
        .axi4lite_awready     (awready),
        .axi4lite_wdata       (wdata),
        .axi4lite_wvalid      (wvalid),
        .axi4lite_wready      (wready),
        .axi4lite_bvalid      (bvalid),
        .axi4lite_bready      (bready),
        .axi4lite_bresp       (bresp),
        .inject_tdata         (tdata),
        .inject_tvalid        (tvalid),
        .inject_tready        (tready),
        .inject_tlast         (tlast),
        .inject_eom           (eom),
        .inject_fifo_count    (fifo_count),
        .inject_overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] stg_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = m_stg[i];
        return v;
    endfunction

    // Handshake occurs at the posedge following the negedge that sees valid&ready
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid) n_tv++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_tdata", tdata, b.d);
                    check("beat_tlast", tlast, b.l);
                    check("beat_eom",   eom,   b.e);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if (rand_rdy) tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [19:0] a, input logic [31:0] d, input int aw_dly,
                          input int w_dly, input int b_hold, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_ok, w_ok;
        int t = 0;
        awaddr = a;
        wdata  = d;
        bready = 1'b0;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            @(negedge clk);
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_ok) aw_done = 1;
            if (w_ok)  w_done  = 1;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_accept_timeout", aw_done && w_done, 1'b1);
        t = 0;
        while (!bvalid && t < 20) begin
            tick(1);
            t++;
        end
        check("bvalid_timeout", bvalid, 1'b1);
        for (int i = 0; i < b_hold; i++) begin
            // a competing write must not be accepted while the response waits
            awaddr  = BASE + 20'h0C;
            wdata   = 32'hDEAD_BEEF;
            awvalid = 1'b1;
            wvalid  = 1'b1;
            check("bvalid_held", bvalid, 1'b1);
            check("awready_in_resp", awready, 1'b0);
            check("wready_in_resp",  wready,  1'b0);
            tick(1);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        @(negedge clk);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wr_dw(input int n, input logic [31:0] v);
        logic [1:0] r;
        axi_wr(BASE + 20'(n * 4), v, 0, 0, 0, r);
        check("bresp_dw", r, 2'b00);
        m_stg[n] = v;
    endtask

    task automatic commit(input logic [31:0] ctl, input logic [1:0] exp_resp);
        logic [1:0] r;
        if (ctl[31] && exp_resp == 2'b00)
            exp_q.push_back('{d: stg_line(), l: ctl[0], e: ctl[1]});
        axi_wr(BASE + 20'h40, ctl, 0, 0, 0, r);
        check("bresp_commit", r, exp_resp);
    endtask

    task automatic drain();
        int t = 0;
        tready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        tick(2);
        check("drain_empty", 1'(exp_q.size() == 0), 1'b1);
        check("drain_tvalid", tvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic [31:0] v;
        int k, m;

        for (int i = 0; i < 16; i++) m_stg[i] = 32'h0;
        rst_n = 1'b0; sw_reset = 1'b0; enable = 1'b0; tready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        tick(3);
        check("rst_awready", awready, 1'b1);
        check("rst_wready",  wready,  1'b1);
        check("rst_bvalid",  bvalid,  1'b0);
        check("rst_bresp",   bresp,   2'b00);
        check("rst_tvalid",  tvalid,  1'b0);
        check("rst_tdata",   tdata,   512'h0);
        check("rst_tlast",   tlast,   1'b0);
        check("rst_eom",     eom,     1'b0);
        check("rst_count",   fifo_count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // single counted line, streamed immediately
        enable = 1'b1; tready = 1'b1;
        for (int n = 0; n < 16; n++) wr_dw(n, 32'(n));
        n_tv = 0;
        commit(32'h8000_0003, 2'b00);
        drain();
        check("single_tvalid_cycles", n_tv, 1);

        // overflow: stage + DEPTH lines accepted, one more dropped
        tready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_dw(0, 32'h1000_0000 + 32'(i));
            commit(32'h8000_0000, (i == DEPTH + 1) ? 2'b10 : 2'b00);
        end
        check("ovf_count",    fifo_count, 5'd16);
        check("ovf_flag",     overflow,   1'b1);
        check("ovf_tvalid",   tvalid,     1'b1);
        drain();

        // held beat survives enable drop; no new load until re-enabled
        tready = 1'b0;
        wr_dw(1, $urandom);
        commit(32'h8000_0001, 2'b00);
        tick(2);
        check("hold_tvalid", tvalid, 1'b1);
        enable = 1'b0;
        wr_dw(1, $urandom);
        commit(32'h8000_0002, 2'b00);
        tick(3);
        check("hold_still_valid", tvalid, 1'b1);
        check("hold_count", fifo_count, 5'd1);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        tick(3);
        check("hold_blocked_tvalid", tvalid, 1'b0);
        check("hold_blocked_count", fifo_count, 5'd1);
        enable = 1'b1;
        tick(2);
        check("hold_resumed_tvalid", tvalid, 1'b1);
        drain();

        // ignored writes: unmapped offset and window miss
        axi_wr(BASE + 20'h44, 32'h8000_0003, 0, 0, 0, r);
        check("bresp_off44", r, 2'b00);
        axi_wr(BASE + 20'h100, 32'h8000_0003, 0, 0, 0, r);
        check("bresp_miss", r, 2'b00);
        axi_wr(BASE + 20'h104, 32'h1234_5678, 0, 0, 0, r);
        check("bresp_miss_dw", r, 2'b00);
        tick(3);
        check("ignored_count",  fifo_count, 5'd0);
        check("ignored_tvalid", tvalid, 1'b0);

        // AW/W ordering and held response
        v = $urandom;
        axi_wr(BASE + 20'h08, v, 0, 3, 5, r);
        check("bresp_aw_first", r, 2'b00);
        m_stg[2] = v;
        v = $urandom;
        axi_wr(BASE + 20'h10, v, 3, 0, 5, r);
        check("bresp_w_first", r, 2'b00);
        m_stg[4] = v;
        tick(2);
        check("order_count", fifo_count, 5'd0);
        commit(32'h8000_0002, 2'b00);
        drain();

        // software reset with a beat pending
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_dw(i + 8, $urandom);
            commit(32'h8000_0001, 2'b00);
        end
        tick(2);
        check("pre_swr_count",  fifo_count, 5'd3);
        check("pre_swr_tvalid", tvalid, 1'b1);
        sw_reset = 1'b1;
        tick(1);
        sw_reset = 1'b0;
        check("swr_tvalid",   tvalid,     1'b0);
        check("swr_count",    fifo_count, 5'd0);
        check("swr_overflow", overflow,   1'b0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_stg[i] = 32'h0;
        tready = 1'b1;
        commit(32'h8000_0000, 2'b00);
        drain();

        // randomized lines under random backpressure
        for (int round = 0; round < 4; round++) begin
            rand_rdy = 1'b1;
            k = $urandom_range(1, 6);
            for (int c = 0; c < k; c++) begin
                m = $urandom_range(1, 4);
                for (int j = 0; j < m; j++) wr_dw($urandom_range(0, 15), $urandom);
                commit(32'h8000_0000 | 32'($urandom_range(0, 3)), 2'b00);
            end
            rand_rdy = 1'b0;
            tick(1);
            drain();
        end
        check("final_overflow", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zuc_inject_buf.md
Name: zuc_inject_buf

Overview:
- Transmit-side counterpart of the ZUC 512b axi4stream sampling buffer.
- Software loads 512b lines plus sideband over AXI4Lite writes, one 32b DW at a time, into a staging register, then commits each line into an internal FIFO.
- The block replays committed lines as an axi4stream master toward the ZUC datapath, for directed stimulus injection.
- It sits in the same clock domain as the AXI4Lite control path.

Parameters:
DEPTH, 16, FIFO depth in 516b lines; power of 2, minimum 2.
CW, $clog2(DEPTH)+1, width of the fill count.

Ports:
inject_clk  in  1  sole clock.
inject_reset_n  in  1  asynchronous, active-low reset.
inject_sw_reset  in  1  synchronous active-high datapath clear.
inject_enable  in  1  permits starting new stream beats.
axi4lite_awaddr_base  in  20  window base; bits [7:0] are zero.
axi4lite_awaddr  in  20  write address.
axi4lite_awvalid  in  1  write address valid.
axi4lite_awready  out  1  write address ready.
axi4lite_wdata  in  32  write data.
axi4lite_wvalid  in  1  write data valid.
axi4lite_wready  out  1  write data ready.
axi4lite_bvalid  out  1  write response valid.
axi4lite_bready  in  1  write response ready.
axi4lite_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
inject_tdata  out  512  stream data.
inject_tvalid  out  1  stream valid.
inject_tready  in  1  stream ready.
inject_tlast  out  1  end-of-packet marker.
inject_eom  out  1  end-of-message marker.
inject_fifo_count  out  CW  lines held in the FIFO, excluding the output stage.
inject_overflow  out  1  sticky flag: a commit was dropped.

Behaviour:
- Reset (inject_reset_n=0) clears all state.
  - Outputs: awready=1, wready=1, bvalid=0, bresp=00, tvalid=0, tdata=0, tlast=0, eom=0, fifo_count=0, overflow=0.
  - Staging register is zeroed.
- Address map (hit when {awaddr[19:8],8'h00}==base):
  - base+0x00..0x3C: DW n=awaddr[7:2] is written to staging[32n+31:32n].
  - base+0x40: control word. Bit0 is tlast, bit1 is eom, bit31 is commit.
  - Any other offset, or a miss: write is ignored, bresp=00.
- AXI write FSM states:
  - IDLE: awready=wready=1. The AW and W beats are captured independently; each ready drops once its beat is taken. When both are held, go to APPLY. AW and W accepted in the same cycle go to APPLY on the next edge.
  - APPLY: 1 cycle. Update staging, or perform the commit. Set bresp. Go to RESP.
  - RESP: bvalid=1 until bready; then go to IDLE and set awready=wready=1.
- Commit: the 516b word {eom, tlast, 2'b00, staging[511:0]} is pushed into the FIFO.
  - Push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the line is dropped, overflow is set to 1, and bresp=10.
  - Staging is retained after commit, so repeated lines need only their changed DWs rewritten.
  - A control write with bit31=0 updates only the latched tlast/eom bits.
- Output stage: a registered stage feeds the stream outputs.
  - It loads from the FIFO head when the stage is empty or being consumed (tvalid&tready), FIFO is non-empty, and inject_enable=1.
  - Latency: a line committed at edge N can assert tvalid from edge N+1.
  - Throughput is one beat per cycle while tready=1.
  - Once tvalid=1, tdata/tlast/eom stay stable and tvalid stays high until tready, even if inject_enable drops.
  - Deasserting inject_enable only blocks new loads.
- fifo_count: pointer difference, with wrap on the DEPTH-power-of-2 pointers. Push+pop in the same cycle leaves it unchanged.
- inject_sw_reset (synchronous):
  - Clears FIFO pointers, output stage (tvalid=0), staging, latched tlast/eom, and overflow.
  - The AXI FSM is untouched, so a pending bvalid still completes.
  - A commit in the same cycle as sw_reset is dropped without setting overflow; bresp=00.
- Asynchronous reset mid-transfer aborts everything. The bench must not expect the beat in flight.

Test Plan:
- Write DW0..15 = 32'h0000_0000+n, then control 0x8000_0003, with enable=1 and tready=1.
  - bresp=00.
  - One beat with tdata[32n+31:32n]=n, tlast=1, eom=1; tvalid high exactly 1 cycle.
- enable=1, tready=0; commit DEPTH+2 lines.
  - The first DEPTH+1 lines are accepted: DEPTH in the FIFO plus one in the output stage.
  - The last commit gets bresp=10 and overflow=1; fifo_count=16.
- With tvalid=1 and tready=0, drop inject_enable, then pulse tready.
  - The held beat completes unchanged.
  - No further tvalid until enable=1.
- Issue AW three cycles before W, then W before AW, and hold bready=0 for 5 cycles.
  - Each write is applied exactly once.
  - bvalid is held for those 5 cycles; no second transaction is accepted meanwhile.
- Write to base+0x44 and to base+0x100.
  - Both return bresp=00; staging and FIFO are unchanged.
- Fill 4 lines, then pulse sw_reset while a stream beat is pending.
  - tvalid=0 and fifo_count=0 next cycle; overflow=0.
  - A subsequent commit streams all-zero data.
